// File: rtl/port_rd_pkg.sv
// Shared register map for the switch read responder.
// Offsets are relative to the responder's BASE_ID.
package port_rd_pkg;

    localparam logic [15:0] RD_SW_NOW   = 16'd0;
    localparam logic [15:0] RD_SW_EVENT = 16'd1;
    localparam logic [15:0] RD_STATUS   = 16'd2;

    localparam int ST_IRQ_BIT = 0;
    localparam int ST_OVF_BIT = 1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_NOW,
        SEL_EVENT,
        SEL_STATUS
    } rd_sel_e;

    function automatic rd_sel_e rd_decode(
        input logic [15:0] port_id,
        input logic [15:0] base_id
    );
        rd_sel_e sel;
        sel = SEL_NONE;
        if (port_id == base_id + RD_SW_NOW)   sel = SEL_NOW;
        if (port_id == base_id + RD_SW_EVENT) sel = SEL_EVENT;
        if (port_id == base_id + RD_STATUS)   sel = SEL_STATUS;
        return sel;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with either-edge change detection.
// chg is a one-cycle pulse per bit when the synchronized level moves.
module sync_edge #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] chg
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign q   = s2_q;
    assign chg = s2_q ^ prev_q;

endmodule

// File: rtl/port_read_responder.sv
// Switch read responder: level, sticky change flags and status on IN_PORT.
// Define SW_EVENT_IRQ_EN to enable the change interrupt.
module port_read_responder
    import port_rd_pkg::*;
#(
    parameter int          SW_W    = 16,
    parameter logic [15:0] BASE_ID = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] sw,
    input  logic [15:0]     port_id,
    input  logic            read_strobe,
    input  logic            interrupt_ack,
    output logic [15:0]     in_port,
    output logic            interrupt
);

    logic [SW_W-1:0] sw_now;
    logic [SW_W-1:0] chg;
    logic [SW_W-1:0] ev_q, ev_d;
    logic            ovf_q, ovf_d;
    logic            irq_pending;
    rd_sel_e         sel;
    logic            rd_event;
    logic            rd_status;
    logic [15:0]     now16;
    logic [15:0]     ev16;
    logic [15:0]     status16;

    sync_edge #(
        .W(SW_W)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sw),
        .q    (sw_now),
        .chg  (chg)
    );

    assign sel       = rd_decode(port_id, BASE_ID);
    assign rd_event  = read_strobe && (sel == SEL_EVENT);
    assign rd_status = read_strobe && (sel == SEL_STATUS);

    // A read hands back every set flag, so it clears all of them; new
    // changes in the same cycle are OR-ed in afterwards and survive.
    always_comb begin
        ev_d = rd_event ? '0 : ev_q;
        ev_d = ev_d | chg;
        ovf_d = (ovf_q && !rd_status) || (|(chg & ev_q));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ev_q  <= ev_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef SW_EVENT_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (irq_q && !interrupt_ack) || (|chg);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_pending = irq_q;
    assign interrupt   = irq_q;
`else
    logic unused_ack;

    assign unused_ack  = interrupt_ack;
    assign irq_pending = 1'b0;
    assign interrupt   = 1'b0;
`endif

    always_comb begin
        now16              = '0;
        now16[SW_W-1:0]    = sw_now;
        ev16               = '0;
        ev16[SW_W-1:0]     = ev_q;
        status16           = '0;
        status16[ST_IRQ_BIT] = irq_pending;
        status16[ST_OVF_BIT] = ovf_q;
    end

    always_comb begin
        in_port = 16'h0000;
        unique case (sel)
            SEL_NOW:    in_port = now16;
            SEL_EVENT:  in_port = ev16;
            SEL_STATUS: in_port = status16;
            default:    in_port = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_port_read_responder.sv
// Scoreboard bench for port_read_responder: reads push expectations,
// a negedge monitor pops and checks in_port and interrupt.
module tb_port_read_responder;

    localparam logic [15:0] BASE = 16'h0010;
    localparam logic [15:0] NOW  = BASE + 16'd0;
    localparam logic [15:0] SWE  = BASE + 16'd1;
    localparam logic [15:0] ST   = BASE + 16'd2;

`ifdef SW_EVENT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] port_id;
    logic        read_strobe;
    logic        interrupt_ack;
    logic [15:0] in_port;
    logic        interrupt;

    typedef struct {
        logic [15:0] d;
        logic        irq;
        string       nm;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    port_read_responder #(
        .SW_W   (16),
        .BASE_ID(BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .interrupt_ack(interrupt_ack),
        .in_port      (in_port),
        .interrupt    (interrupt)
    );

    function automatic logic [15:0] st(input bit ov, input bit irq);
        return {14'b0, ov, irq & IRQ_EN};
    endfunction

    always @(negedge clk) begin
        if (read_strobe) begin
            item_t it;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: port_id=%h in_port=%h, no expectation queued",
                         port_id, in_port);
            end else begin
                it = q.pop_front();
                if (in_port !== it.d) begin
                    bad++;
                    $display("FAIL %s in_port: got %h want %h", it.nm, in_port, it.d);
                end
                total++;
                if (interrupt !== (it.irq & IRQ_EN)) begin
                    bad++;
                    $display("FAIL %s interrupt: got %b want %b", it.nm, interrupt,
                             it.irq & IRQ_EN);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] id, input logic [15:0] d,
                      input bit irq, input string nm);
        item_t it;
        it.d = d; it.irq = irq; it.nm = nm;
        port_id = id;
        read_strobe = 1'b1;
        q.push_back(it);
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        reset = 1'b0;
        sw = 16'hA5A5;
        port_id = 16'h0000;
        read_strobe = 1'b0;
        interrupt_ack = 1'b0;

        // reset with switches held high
        tick();
        rd(SWE, 16'h0000, 0, "rst_swe");
        reset = 1'b1;
        tick(3);
        rd(SWE, 16'hA5A5, 1, "fill_swe");
        rd(NOW, 16'hA5A5, 1, "fill_now");
        rd(ST, st(0, 1), 1, "fill_st");
        ack();
        rd(ST, st(0, 0), 0, "fill_st_ack");
        rd(SWE, 16'h0000, 0, "fill_swe_clr");

        // settle to zero, then single bit rise
        sw = 16'h0000;
        tick(4);
        rd(SWE, 16'hA5A5, 1, "fall_swe");
        rd(ST, st(0, 1), 1, "fall_st");
        ack();
        sw = 16'h0001;
        tick(4);
        rd(SWE, 16'h0001, 1, "b0_swe");
        rd(SWE, 16'h0000, 1, "b0_swe_clr");
        ack();
        rd(NOW, 16'h0001, 0, "b0_now_ack");

        // bit 3 toggled twice -> overflow
        sw = 16'h0009;
        tick(2);
        sw = 16'h0001;
        tick(4);
        rd(ST, st(1, 1), 1, "ovf_st");
        rd(ST, st(0, 1), 1, "ovf_st_clr");
        rd(SWE, 16'h0008, 1, "ovf_swe");
        ack();

        // bit 5 event coincident with a clearing read
        sw = 16'h0021;
        tick(2);
        rd(SWE, 16'h0000, 0, "coinc_swe");
        rd(SWE, 16'h0020, 1, "coinc_keep");
        rd(ST, st(0, 1), 1, "coinc_st");
        ack();

        // ack coincident with a new event
        sw = 16'h0020;
        tick(4);
        sw = 16'h0021;
        tick(2);
        ack();
        rd(NOW, 16'h0021, 1, "ackev_now");
        rd(SWE, 16'h0001, 1, "ackev_swe");
        rd(ST, st(1, 1), 1, "ackev_st");
        ack();
        rd(ST, st(0, 0), 0, "ack_alone_st");
        rd(SWE, 16'h0000, 0, "ack_alone_swe");

        // strobe held two cycles on SW_EVENT
        sw = 16'h0000;
        tick(4);
        port_id = SWE;
        read_strobe = 1'b1;
        it.d = 16'h0021; it.irq = 1'b1; it.nm = "hold_1";
        q.push_back(it);
        tick();
        it.d = 16'h0000; it.irq = 1'b1; it.nm = "hold_2";
        q.push_back(it);
        tick();
        read_strobe = 1'b0;
        rd(ST, st(0, 1), 1, "hold_st");
        ack();

        // unmapped and SW_NOW reads have no side effects
        sw = 16'h0004;
        tick(4);
        rd(16'h0007, 16'h0000, 1, "unmap_7");
        rd(BASE + 16'd3, 16'h0000, 1, "unmap_b3");
        rd(NOW, 16'h0004, 1, "side_now");
        rd(SWE, 16'h0004, 1, "side_swe");
        rd(ST, st(0, 1), 1, "side_st");
        ack();

        // reset abandons pending flags and interrupt
        sw = 16'h0000;
        tick(4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd(SWE, 16'h0000, 0, "rstmid_swe");
        rd(ST, st(0, 0), 0, "rstmid_st");
        tick(4);
        rd(SWE, 16'h0000, 0, "rstmid_quiet");
        rd(NOW, 16'h0000, 0, "rstmid_now");

        tick(2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d reads never observed, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
